// File: rtl/seq_stream_rx_if.sv
// Stream-side and buffer-side signals of the sequence receiver.
// The master drives the beats and the pops; the slave is the receiver.
interface seq_stream_rx_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              overflow;
  logic              synced;
  logic              seq_err;
  logic [CNT_W-1:0]  beat_count;
  logic [CNT_W-1:0]  err_count;

  modport master (
    output in_valid, in_data, rd_en,
    input  rd_data, rd_valid, full, overflow, synced, seq_err, beat_count, err_count
  );

  modport slave (
    input  in_valid, in_data, rd_en,
    output rd_data, rd_valid, full, overflow, synced, seq_err, beat_count, err_count
  );
endinterface

// File: rtl/seq_stream_rx.sv
// Receiver for an incrementing valid/data stream: checks the sequence, buffers
// beats in a first-word-fall-through FIFO and keeps beat/error/overflow statistics.
module seq_stream_rx #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input logic            clk,
  input logic            rst,
  input logic            clr,
  seq_stream_rx_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, SYNCED = 1'b1} state_t;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] expected;
  logic [DATA_W-1:0] expected_next;
  logic              mismatch;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;

  logic              seq_err;
  logic              overflow;
  logic [CNT_W-1:0]  beat_count;
  logic [CNT_W-1:0]  err_count;

  logic wipe;
  logic beat;
  logic full;
  logic rd_valid;
  logic push;
  logic pop;
  logic drop;

  // A beat arriving during reset/clear is discarded entirely.
  assign wipe     = rst | clr;
  assign beat     = bus.in_valid & ~wipe;
  assign full     = (count == (AW+1)'(DEPTH));
  assign rd_valid = (count != {(AW+1){1'b0}});
  assign push     = beat & (~full | bus.rd_en);
  assign pop      = ~wipe & bus.rd_en & rd_valid;
  assign drop     = beat & full & ~bus.rd_en;

  // Checker state and expected-value register.
  always_ff @(posedge clk) begin
    if (wipe) begin
      state    <= IDLE;
      expected <= {DATA_W{1'b0}};
    end else begin
      state    <= state_next;
      expected <= expected_next;
    end
  end

  // Checker next state: the first beat locks, after that it stays locked.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (beat) begin
          state_next = SYNCED;
        end else begin
          state_next = IDLE;
        end
      end
      SYNCED:  state_next = SYNCED;
      default: state_next = IDLE;
    endcase
  end

  // Checker outputs: next expected value and mismatch detection.
  always_comb begin
    expected_next = expected;
    mismatch      = 1'b0;
    case (state)
      IDLE: begin
        if (beat) begin
          expected_next = bus.in_data + DATA_W'(1);
        end else begin
          expected_next = expected;
        end
      end
      SYNCED: begin
        if (beat && (bus.in_data == expected)) begin
          expected_next = expected + DATA_W'(1);
        end else if (beat) begin
          mismatch      = 1'b1;
          expected_next = bus.in_data + DATA_W'(1);
        end else begin
          expected_next = expected;
        end
      end
      default: begin
        expected_next = {DATA_W{1'b0}};
        mismatch      = 1'b0;
      end
    endcase
  end

  // Statistics: saturating counters, error pulse and sticky overflow.
  always_ff @(posedge clk) begin
    if (wipe) begin
      seq_err    <= 1'b0;
      overflow   <= 1'b0;
      beat_count <= {CNT_W{1'b0}};
      err_count  <= {CNT_W{1'b0}};
    end else begin
      seq_err <= mismatch;
      if (drop) begin
        overflow <= 1'b1;
      end
      if (beat && (beat_count != {CNT_W{1'b1}})) begin
        beat_count <= beat_count + CNT_W'(1);
      end
      if (mismatch && (err_count != {CNT_W{1'b1}})) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (wipe) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {(AW+1){1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  assign bus.rd_data    = mem[rd_ptr];
  assign bus.rd_valid   = rd_valid;
  assign bus.full       = full;
  assign bus.overflow   = overflow;
  assign bus.synced     = (state == SYNCED);
  assign bus.seq_err    = seq_err;
  assign bus.beat_count = beat_count;
  assign bus.err_count  = err_count;
endmodule

// File: doc/seq_stream_rx.md
Name: seq_stream_rx

Overview:
- Receiving end of the 8-bit valid/data stream interface; transmitters drive one beat per clock, incrementing data.
- Samples every valid beat.
- Checks that each beat equals the previous beat plus one, modulo 2^DATA_W.
- Buffers beats in a small first-word-fall-through FIFO and keeps beat, error and overflow statistics for the bench or downstream logic.

Parameters:
- DATA_W, 8, width of the data field.
- DEPTH, 8, FIFO entries; must be a power of two, minimum 2.
- CNT_W, 16, width of the beat and error counters.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- clr  input  1  synchronous soft clear; same effect as rst.
- in_valid  input  1  beat qualifier; there is no backpressure.
- in_data  input  DATA_W  beat payload.
- rd_en  input  1  pop the FIFO head.
- rd_data  output  DATA_W  FIFO head, valid while rd_valid=1.
- rd_valid  output  1  FIFO not empty.
- full  output  1  FIFO holds DEPTH entries.
- overflow  output  1  sticky flag: a beat was dropped.
- synced  output  1  sequence checker is locked.
- seq_err  output  1  one-cycle pulse on a sequence mismatch.
- beat_count  output  CNT_W  valid beats observed, including dropped beats.
- err_count  output  CNT_W  sequence mismatches.

Behaviour:
- Reset values (rst=1 or clr=1), effective next edge:
  - rd_valid=0, full=0, overflow=0, synced=0, seq_err=0, beat_count=0, err_count=0.
  - FIFO pointers=0; rd_data is don't-care.
  - expected register=0.
- rst and clr win over every other input in the same cycle; an in_valid beat in that cycle is discarded and not counted.
- Checker FSM, two states, IDLE and SYNCED:
  - IDLE, in_valid=1: expected<=in_data+1 (truncated to DATA_W), go to SYNCED, no error.
  - SYNCED, in_valid=1 and in_data==expected: expected<=expected+1.
  - SYNCED, in_valid=1 and in_data!=expected: seq_err=1 in the next cycle, err_count+1, expected<=in_data+1 (resynchronise), stay in SYNCED.
  - in_valid=0: no change.
  - synced = (state==SYNCED).
- Wrap-around: 0xFF followed by 0x00 is legal, with no error.
- beat_count increments on every in_valid=1 cycle outside reset.
- Both counters saturate at all-ones and never wrap.
- FIFO push: in_valid=1 and (not full, or rd_en=1 in the same cycle).
  - Simultaneous push and pop while full: both happen and occupancy stays at DEPTH.
- FIFO drop: in_valid=1, full=1, rd_en=0. The beat is discarded and overflow<=1, sticky until rst or clr. The checker and beat_count still process the dropped beat.
- FIFO pop: rd_en=1 and rd_valid=1. rd_en while empty is ignored, with no pointer change.
- Simultaneous push and pop while empty: push only; the pop is ignored.
- Latency: a beat sampled at edge N appears on rd_data/rd_valid after edge N (first-word fall-through, rd_data driven combinationally from the head entry).
- full and rd_valid are derived from an occupancy counter of width log2(DEPTH)+1; pointers wrap modulo DEPTH.
- Reset mid-stream: all buffered data is lost. The next valid beat re-locks the checker from IDLE with no error.

Test Plan:
- Reset, then 10 beats with data 0..9, rd_en=1 throughout → rd_data 0..9 in order, each one cycle after its beat; beat_count=10, err_count=0, synced=1 after the first beat, overflow=0.
- Beats 0xFD,0xFE,0xFF,0x00,0x01 → no seq_err; err_count=0 (wrap-around legal).
- Beats 5,6,9,10 → one seq_err pulse the cycle after 9; err_count=1; beat 10 is accepted with no further error.
- rd_en=0, 10 consecutive beats with DEPTH=8 → full=1 after the 8th; beats 9 and 10 are dropped; overflow=1; beat_count=10. Draining then yields exactly the first 8 values and rd_valid=0.
- FIFO full, in_valid=1 and rd_en=1 in the same cycle → occupancy stays 8, full stays 1, overflow stays 0, and the new beat appears after the existing 7 entries.
- Mid-stream: after 3 beats, assert clr for 1 cycle together with in_valid → all outputs return to reset values and the beat is not counted; the next beat 0x40 re-locks with synced=1, seq_err=0, beat_count=1.
